video_timing_ctrl: RTL

- Programmable raster timing controller that sequences the HDMI pixel datapath.
- Generates blank/hsync/vsync for the TMDS encoders, plus pixel coordinates and a one-cycle-early pixel request for pattern or frame sources.
- Start and stop are frame-aligned: the link never sees a truncated frame.
- Sits between the top level and the test pattern / video encoder, all on the pixel clock.

---
 rtl/video_timing_ctrl_pkg.sv | 29 ++
 rtl/video_timing_ctrl_if.sv | 28 ++
 rtl/video_timing_ctrl_axis_counter.sv | 26 ++
 rtl/video_timing_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/video_timing_ctrl_pkg.sv
// Shared types and constants for the raster timing controller (package video_pkg).
package video_pkg;

    localparam int VTC_CNT_W       = 12;
    localparam int VTC_FRAME_CNT_W = 16;

    typedef struct packed {
        logic [VTC_CNT_W-1:0] h_active;
        logic [VTC_CNT_W-1:0] h_fp;
        logic [VTC_CNT_W-1:0] h_sync;
        logic [VTC_CNT_W-1:0] h_bp;
        logic [VTC_CNT_W-1:0] v_active;
        logic [VTC_CNT_W-1:0] v_fp;
        logic [VTC_CNT_W-1:0] v_sync;
        logic [VTC_CNT_W-1:0] v_bp;
        logic                 hs_pol;
        logic                 vs_pol;
    } video_timing_t;

    typedef enum logic [1:0] {IDLE, RUN, STOP_PEND} vtc_state_t;

    // 640x480@60 with negative sync polarities
    localparam video_timing_t VTC_TIMING_640X480 = '{
        h_active: 12'd640, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48,
        v_active: 12'd480, v_fp: 12'd10, v_sync: 12'd2,  v_bp: 12'd33,
        hs_pol:   1'b0,    vs_pol: 1'b0
    };

endpackage

// File: rtl/video_timing_ctrl_if.sv
// Raster output bundle: enable in, sync/blank/coordinates out.
interface video_timing_ctrl_if import video_pkg::*; ();

    logic                       enable;
    logic                       running;
    logic                       blank;
    logic                       hsync;
    logic                       vsync;
    logic                       pix_req;
    logic [VTC_CNT_W-1:0]       x;
    logic [VTC_CNT_W-1:0]       y;
    logic                       line_start;
    logic                       frame_start;
    logic [VTC_FRAME_CNT_W-1:0] frame_cnt;

    modport master (
        input  enable,
        output running, blank, hsync, vsync, pix_req, x, y,
               line_start, frame_start, frame_cnt
    );

    modport slave (
        output enable,
        input  running, blank, hsync, vsync, pix_req, x, y,
               line_start, frame_start, frame_cnt
    );

endinterface

// File: rtl/video_timing_ctrl_axis_counter.sv
// Wrapping axis counter (module video_axis_counter): counts 0..max_val, flags last.
module video_axis_counter import video_pkg::*; #(
    parameter int W = VTC_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clear,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] count,
    output logic         last
);

    assign last = (count == max_val);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/video_timing_ctrl.sv
// Programmable raster timing controller with frame-aligned start/stop.
// Optional frame counter enabled by defining VIDEO_TIMING_FRAME_CNT_EN.
//
// state     | meaning
// IDLE      | counters held at 0, outputs at reset values
// RUN       | raster running, enable high
// STOP_PEND | enable dropped, finishing the current frame
module video_timing_ctrl import video_pkg::*; #(
    parameter int H_ACTIVE = int'(VTC_TIMING_640X480.h_active),
    parameter int H_FP     = int'(VTC_TIMING_640X480.h_fp),
    parameter int H_SYNC   = int'(VTC_TIMING_640X480.h_sync),
    parameter int H_BP     = int'(VTC_TIMING_640X480.h_bp),
    parameter int V_ACTIVE = int'(VTC_TIMING_640X480.v_active),
    parameter int V_FP     = int'(VTC_TIMING_640X480.v_fp),
    parameter int V_SYNC   = int'(VTC_TIMING_640X480.v_sync),
    parameter int V_BP     = int'(VTC_TIMING_640X480.v_bp),
    parameter bit HS_POL   = VTC_TIMING_640X480.hs_pol,
    parameter bit VS_POL   = VTC_TIMING_640X480.vs_pol
) (
    input  logic                clk,
    input  logic                reset,
    video_timing_ctrl_if.master vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CW1     = VTC_CNT_W + 1;

    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_timing
        $error("video_timing_ctrl: H_TOTAL/V_TOTAL exceed the 12-bit counters");
    end

    localparam logic [VTC_CNT_W-1:0] H_MAX    = VTC_CNT_W'(H_TOTAL - 1);
    localparam logic [VTC_CNT_W-1:0] V_MAX    = VTC_CNT_W'(V_TOTAL - 1);
    localparam logic [CW1-1:0]       H_ACT_C  = CW1'(H_ACTIVE);
    localparam logic [CW1-1:0]       V_ACT_C  = CW1'(V_ACTIVE);
    localparam logic [CW1-1:0]       H_HS_S   = CW1'(H_ACTIVE + H_FP);
    localparam logic [CW1-1:0]       H_HS_E   = CW1'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW1-1:0]       V_VS_S   = CW1'(V_ACTIVE + V_FP);
    localparam logic [CW1-1:0]       V_VS_E   = CW1'(V_ACTIVE + V_FP + V_SYNC);

    vtc_state_t           state, state_next;
    logic [VTC_CNT_W-1:0] hcnt, vcnt;
    logic                 h_last, v_last;
    logic                 cnt_en, cnt_clr;
    logic                 act_dec, hs_dec, vs_dec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_en     = 1'b0;
        cnt_clr    = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (vid.enable) state_next = RUN;
            end
            RUN: begin
                cnt_en = 1'b1;
                if (!vid.enable) state_next = STOP_PEND;
            end
            STOP_PEND: begin
                cnt_en = 1'b1;
                // re-enable in the last cycle keeps running; the counters wrap either way
                if (vid.enable)                state_next = RUN;
                else if (h_last && v_last)     state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    video_axis_counter #(.W(VTC_CNT_W)) u_hcnt (
        .clk     (clk),
        .reset   (reset),
        .inc     (cnt_en),
        .clear   (cnt_clr),
        .max_val (H_MAX),
        .count   (hcnt),
        .last    (h_last)
    );

    video_axis_counter #(.W(VTC_CNT_W)) u_vcnt (
        .clk     (clk),
        .reset   (reset),
        .inc     (cnt_en && h_last),
        .clear   (cnt_clr),
        .max_val (V_MAX),
        .count   (vcnt),
        .last    (v_last)
    );

    always_comb begin
        act_dec = ({1'b0, hcnt} < H_ACT_C) && ({1'b0, vcnt} < V_ACT_C);
        hs_dec  = ({1'b0, hcnt} >= H_HS_S) && ({1'b0, hcnt} < H_HS_E);
        vs_dec  = ({1'b0, vcnt} >= V_VS_S) && ({1'b0, vcnt} < V_VS_E);
    end

    // Stage 1 decodes the counters and doubles as the one-cycle-early pixel request.
    logic                 s1_run, s1_act, s1_hs, s1_vs, s1_first;
    logic [VTC_CNT_W-1:0] s1_h, s1_v;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_run <= 1'b0;
            s1_act <= 1'b0;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_h   <= '0;
            s1_v   <= '0;
        end else begin
            s1_run <= cnt_en;
            s1_act <= cnt_en && act_dec;
            s1_hs  <= hs_dec;
            s1_vs  <= vs_dec;
            s1_h   <= hcnt;
            s1_v   <= vcnt;
        end
    end

    assign s1_first = s1_act && (s1_h == '0) && (s1_v == '0);

    logic                 blank_q, hsync_q, vsync_q, ls_q, fs_q;
    logic [VTC_CNT_W-1:0] x_q, y_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blank_q <= 1'b1;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else if (!s1_run) begin
            blank_q <= 1'b1;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            blank_q <= ~s1_act;
            hsync_q <= s1_hs ? HS_POL : ~HS_POL;
            vsync_q <= s1_vs ? VS_POL : ~VS_POL;
            ls_q    <= s1_act && (s1_h == '0);
            fs_q    <= s1_first;
            if (s1_act) begin
                x_q <= s1_h;
                y_q <= s1_v;
            end
        end
    end

`ifdef VIDEO_TIMING_FRAME_CNT_EN
    logic [VTC_FRAME_CNT_W-1:0] frame_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        frame_cnt_q <= '0;
        else if (s1_first) frame_cnt_q <= frame_cnt_q + 1'b1;
    end

    assign vid.frame_cnt = frame_cnt_q;
`else
    assign vid.frame_cnt = '0;
`endif

    assign vid.running     = (state != IDLE);
    assign vid.pix_req     = s1_act;
    assign vid.blank       = blank_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.line_start  = ls_q;
    assign vid.frame_start = fs_q;
    assign vid.x           = x_q;
    assign vid.y           = y_q;

endmodule
